// File: rtl/tristate_bus_pkg.sv
// -----------------------------------------------------------------------------
// tristate_bus_pkg
// Shared types and default constants for the tri-state bus arbiter.
//   state_t        : arbiter FSM states (IDLE, GRANT, TURNAROUND)
//   N_REQ_DEF      : default number of requesters
//   TA_CYCLES_DEF  : default bus turnaround length in cycles
//   HOLD_MAX_DEF   : default maximum consecutive grant cycles (ARB_TIMEOUT_EN)
// -----------------------------------------------------------------------------
package tristate_bus_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GRANT      = 2'd1,
      TURNAROUND = 2'd2
   } state_t;

   localparam int unsigned N_REQ_DEF     = 4;
   localparam int unsigned TA_CYCLES_DEF = 1;
   localparam int unsigned HOLD_MAX_DEF  = 8;

endpackage

// File: rtl/tristate_bus_arbiter_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker: selects the first asserted request at or
// after index (last_owner + 1) mod N_REQ, wrapping around.
//   i_req        [N_REQ-1:0] : request vector
//   i_last_owner [IW-1:0]    : index of the most recent owner
//   o_winner     [N_REQ-1:0] : one-hot winner, zero when no request
//   o_valid                  : at least one request is asserted
// -----------------------------------------------------------------------------
module rr_priority_picker
   import tristate_bus_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_last_owner,
   output logic [N_REQ-1:0] o_winner,
   output logic             o_valid
);

   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         logic [IW-1:0] w_idx;
         w_idx = IW'((32'(i_last_owner) + 32'd1 + k) % N_REQ);
         if (!o_valid && i_req[w_idx]) begin
            o_winner[w_idx] = 1'b1;
            o_valid         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tristate_bus_arbiter
// Round-robin arbiter for N_REQ requesters sharing one tri-state bus. Every
// ownership change passes through TA_CYCLES cycles with all enables low so two
// drivers never overlap.
//   clk               : rising-edge clock
//   rst_n             : asynchronous active-low reset
//   req   [N_REQ-1:0] : level-sensitive bus requests
//   grant [N_REQ-1:0] : registered one-hot (or zero) current owner
//   oe    [N_REQ-1:0] : registered driver enables, identical to grant
//   bus_busy          : registered OR of grant
//   timeout           : one-cycle pulse on forced release
// Optional feature macro ARB_TIMEOUT_EN: limits a grant to HOLD_MAX cycles;
// when undefined a grant is held while the owner requests and timeout is 0.
// -----------------------------------------------------------------------------
module tristate_bus_arbiter
   import tristate_bus_pkg::*;
#(
   parameter int unsigned N_REQ     = N_REQ_DEF,
   parameter int unsigned TA_CYCLES = TA_CYCLES_DEF,
   parameter int unsigned HOLD_MAX  = HOLD_MAX_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [N_REQ-1:0] oe,
   output logic             bus_busy,
   output logic             timeout
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (N_REQ < 2) begin : g_bad_nreq
      $error("N_REQ must be at least 2");
   end
   if (TA_CYCLES < 1 || TA_CYCLES > 15) begin : g_bad_ta
      $error("TA_CYCLES must be in 1..15");
   end
   if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
      $error("HOLD_MAX must be in 2..255");
   end

   state_t           r_state, w_state_nxt;
   logic [N_REQ-1:0] r_grant, w_grant_nxt;
   logic [IW-1:0]    r_last_owner, w_last_nxt;
   logic [3:0]       r_ta_cnt, w_ta_nxt;
   logic             r_busy;
   logic [N_REQ-1:0] w_winner;
   logic             w_valid;
   logic [IW-1:0]    w_win_idx;
   logic             w_owner_req;
   logic             w_hold_hit;

   rr_priority_picker #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_picker (
      .i_req        (req),
      .i_last_owner (r_last_owner),
      .o_winner     (w_winner),
      .o_valid      (w_valid)
   );

   always_comb begin
      w_win_idx = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (w_winner[k]) w_win_idx = IW'(k);
      end
   end

   // r_last_owner tracks the current owner while in GRANT.
   assign w_owner_req = req[r_last_owner];

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last_owner;
      w_ta_nxt    = r_ta_cnt;
      case (r_state)
         IDLE: begin
            if (w_valid) begin
               w_state_nxt = GRANT;
               w_grant_nxt = w_winner;
               w_last_nxt  = w_win_idx;
            end
         end
         GRANT: begin
            if (!w_owner_req || w_hold_hit) begin
               w_state_nxt = TURNAROUND;
               w_grant_nxt = '0;
               w_ta_nxt    = 4'd1;
            end
         end
         TURNAROUND: begin
            if (r_ta_cnt == 4'(TA_CYCLES)) begin
               w_ta_nxt = '0;
               if (w_valid) begin
                  w_state_nxt = GRANT;
                  w_grant_nxt = w_winner;
                  w_last_nxt  = w_win_idx;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_ta_nxt = r_ta_cnt + 4'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_ta_nxt    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_grant      <= '0;
         r_last_owner <= IW'(N_REQ - 1);
         r_ta_cnt     <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_last_owner <= w_last_nxt;
         r_ta_cnt     <= w_ta_nxt;
         r_busy       <= |w_grant_nxt;
      end
   end

`ifdef ARB_TIMEOUT_EN
   logic [7:0] r_hold_cnt;
   logic       r_timeout;

   // Counter holds the number of grant cycles including the current one, so
   // reaching HOLD_MAX means the limit is used up at this edge. A simultaneous
   // owner drop takes the normal-release path and raises no pulse.
   assign w_hold_hit = (r_hold_cnt == 8'(HOLD_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= (r_state == GRANT) && w_owner_req && w_hold_hit;
         if (w_state_nxt == GRANT && r_state != GRANT)
            r_hold_cnt <= 8'd1;
         else if (w_state_nxt == GRANT)
            r_hold_cnt <= r_hold_cnt + 8'd1;
         else
            r_hold_cnt <= '0;
      end
   end

   assign timeout = r_timeout;
`else
   assign w_hold_hit = 1'b0;
   assign timeout    = 1'b0;
`endif

   assign grant    = r_grant;
   assign oe       = r_grant;
   assign bus_busy = r_busy;

endmodule

// File: doc/tristate_bus_arbiter.md
TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one tri-state bus.
REQ-002 SHALL have parameter TA_CYCLES, default 1, bus turnaround cycles with all enables low; legal range 1..15.
REQ-003 SHALL have parameter HOLD_MAX, default 8, maximum consecutive grant cycles; legal range 2..255; used only with ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  N_REQ  per-requester bus request, level-sensitive.
REQ-007 SHALL have port grant  output  N_REQ  one-hot or zero, registered, current bus owner.
REQ-008 SHALL have port oe  output  N_REQ  one-hot or zero, registered, drives control of the owner's bufif1/notif1 driver.
REQ-009 SHALL have port bus_busy  output  1  high when any grant bit is high.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Function
REQ-011 SHALL implement states IDLE, GRANT, TURNAROUND.
REQ-012 IDLE: any req bit high -> GRANT next cycle; no req -> stay IDLE.
REQ-013 Grant latency SHALL be one cycle: req sampled high at edge n in IDLE gives grant/oe high after edge n+1.
REQ-014 Winner SHALL be the first asserted req at or after index (last_owner+1) mod N_REQ, wrapping.
REQ-015 GRANT: grant and oe SHALL equal the same one-hot vector; no other bit may be high.
REQ-016 GRANT: owner's req low at an edge -> TURNAROUND; grant and oe 0 from that edge.
REQ-017 Requests from non-owners during GRANT SHALL be ignored, not queued.
REQ-018 TURNAROUND SHALL last exactly TA_CYCLES cycles with grant and oe all 0 (no-contention guarantee).
REQ-019 TURNAROUND end: any req high -> GRANT by the REQ-014 rule; otherwise IDLE.
REQ-020 Released owner SHALL have lowest priority in the next arbitration; a lone requester is regranted after TA_CYCLES.
REQ-021 A req bit that drops before being granted SHALL NOT be granted.
REQ-022 bus_busy SHALL be the OR of grant, registered.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE; grant, oe = 0; bus_busy, timeout = 0; last_owner = N_REQ-1 (index 0 highest priority); counters 0.
REQ-024 Reset asserted during GRANT SHALL drop oe asynchronously, without waiting for turnaround.
REQ-025 First arbitration after rst_n rises SHALL occur at the first clock edge with req nonzero.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN defined: hold counter counts GRANT cycles; after HOLD_MAX cycles with owner req still high, SHALL force TURNAROUND and pulse timeout for one cycle.
REQ-027 Owner req dropping on the same edge the limit is reached SHALL count as normal release, no timeout pulse.
REQ-028 Macro undefined: no hold counter; grant held indefinitely while owner req high; timeout tied 0.

Structure
REQ-029 Package tristate_bus_pkg SHALL hold the state enum (IDLE, GRANT, TURNAROUND) and default constants for N_REQ, TA_CYCLES, HOLD_MAX.
REQ-030 Combinational sub-module rr_priority_picker (req, last_owner -> one-hot winner, valid) SHALL implement REQ-014.

Verification (N_REQ=4, TA_CYCLES=1, HOLD_MAX=8)
REQ-031 Reset release, req=4'b0101 -> next edge grant=oe=4'b0001, bus_busy=1.
REQ-032 Owner 0 drops req with req=4'b0100 held -> one cycle oe=0, then grant=4'b0100.
REQ-033 req=4'b1111 held, each owner releases after 2 cycles -> grant order 0001,0010,0100,1000,0001, one zero cycle between each.
REQ-034 ARB_TIMEOUT_EN, req=4'b0010 held 20 cycles -> grant 8 cycles, timeout pulse, 1 zero cycle, regrant 4'b0010.
REQ-035 rst_n low mid-GRANT with oe=4'b1000 -> oe=0 before next clock edge; state IDLE.
REQ-036 Random req over 10k cycles -> assertion: grant one-hot or zero, oe==grant, never two owners on adjacent cycles.
